// File: rtl/herring_bus_controller.sv
// 6502 bus controller: PHI2 generator dividing clk_src by DIVISOR, chip-select decode
// and per-window PHI2-high stretching (STRETCH state only when HERRING_WAIT_STATE_EN is defined).
module herring_bus_controller #(
  parameter int unsigned         DIVISOR  = 50,
  parameter int unsigned         NUM_CS   = 4,
  parameter logic [6*NUM_CS-1:0] CS_MATCH = {6'h23, 6'h22, 6'h21, 6'h20},
  parameter logic [6*NUM_CS-1:0] CS_MASK  = {4{6'h3F}},
  parameter logic [4*NUM_CS-1:0] CS_WAIT  = 16'h0001
) (
  input  logic              clk_src,
  input  logic              reset,
  input  logic              cpu_clk_out,
  output logic              cpu_clk_in,
  input  logic [15:10]      address,
  input  logic              rw,
  output logic [NUM_CS-1:0] cs_n,
  output logic              ram_we_n,
  output logic              wait_active
);

  localparam int unsigned HALF  = DIVISOR / 2;
  localparam int unsigned CNT_W = ($clog2(HALF) > 5) ? $clog2(HALF) : 5;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);

  logic [3:0] win_wait;
  logic       found;

  // Lowest-index matching window wins; its wait count rides along for the LOW->HIGH latch.
  always_comb begin
    cs_n     = '1;
    win_wait = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < NUM_CS; i++) begin
      if (!found && (((address ^ CS_MATCH[6*i +: 6]) & CS_MASK[6*i +: 6]) == 6'd0)) begin
        cs_n[i]  = 1'b0;
        win_wait = CS_WAIT[4*i +: 4];
        found    = 1'b1;
      end
    end
  end

  assign ram_we_n = ~(cpu_clk_out & ~rw);

`ifdef HERRING_WAIT_STATE_EN
  typedef enum logic [1:0] {LOW, HIGH, STRETCH} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       wcnt_q;
  logic             clk_q;
  logic             wait_q;

  always_ff @(posedge clk_src or posedge reset) begin
    if (reset) begin
      state_q <= LOW;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      clk_q   <= 1'b0;
      wait_q  <= 1'b0;
    end else begin
      cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      case (state_q)
        LOW: if (cnt_q == CNT_LAST) begin
          state_q <= HIGH;
          clk_q   <= 1'b1;
          wcnt_q  <= win_wait;
        end
        HIGH: if (cnt_q == CNT_LAST) begin
          if (wcnt_q != 4'd0) begin
            state_q <= STRETCH;
            wait_q  <= 1'b1;
          end else begin
            state_q <= LOW;
            clk_q   <= 1'b0;
          end
        end
        STRETCH: if (cnt_q == CNT_LAST) begin
          wcnt_q <= wcnt_q - 4'd1;
          if (wcnt_q == 4'd1) begin
            state_q <= LOW;
            clk_q   <= 1'b0;
            wait_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= LOW;
          clk_q   <= 1'b0;
          wait_q  <= 1'b0;
        end
      endcase
    end
  end

  assign wait_active = wait_q;
`else
  typedef enum logic {LOW, HIGH} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             clk_q;
  logic             unused_wait;

  assign unused_wait = ^win_wait;

  always_ff @(posedge clk_src or posedge reset) begin
    if (reset) begin
      state_q <= LOW;
      cnt_q   <= '0;
      clk_q   <= 1'b0;
    end else begin
      cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      case (state_q)
        LOW: if (cnt_q == CNT_LAST) begin
          state_q <= HIGH;
          clk_q   <= 1'b1;
        end
        HIGH: if (cnt_q == CNT_LAST) begin
          state_q <= LOW;
          clk_q   <= 1'b0;
        end
        default: begin
          state_q <= LOW;
          clk_q   <= 1'b0;
        end
      endcase
    end
  end

  assign wait_active = 1'b0;
`endif

  assign cpu_clk_in = clk_q;

endmodule

// File: tb/tb_herring_bus_controller.sv
// Bench for herring_bus_controller: default DUT plus one with a widened cs1 mask,
// both compared every clk_src cycle against a cycle-length model of PHI2.
module tb_herring_bus_controller;

`ifdef HERRING_WAIT_STATE_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif
  localparam int HALF = 25;

  logic       clk_src = 1'b0;
  logic       reset = 1'b1;
  logic       cpu_clk_out = 1'b0;
  logic       rw = 1'b1;
  logic [5:0] address = 6'h20;

  logic       cpu_clk_in_a, wait_a, ram_we_n_a;
  logic [3:0] cs_n_a;
  logic       cpu_clk_in_b, wait_b, ram_we_n_b;
  logic [3:0] cs_n_b;

  herring_bus_controller #(
    .DIVISOR(50), .NUM_CS(4)
  ) u_dut_a (
    .clk_src(clk_src), .reset(reset), .cpu_clk_out(cpu_clk_out), .cpu_clk_in(cpu_clk_in_a),
    .address(address), .rw(rw), .cs_n(cs_n_a), .ram_we_n(ram_we_n_a), .wait_active(wait_a)
  );

  herring_bus_controller #(
    .DIVISOR(50), .NUM_CS(4),
    .CS_MASK({6'h3F, 6'h3F, 6'h20, 6'h3F})
  ) u_dut_b (
    .clk_src(clk_src), .reset(reset), .cpu_clk_out(cpu_clk_out), .cpu_clk_in(cpu_clk_in_b),
    .address(address), .rw(rw), .cs_n(cs_n_b), .ram_we_n(ram_we_n_b), .wait_active(wait_b)
  );

  always #5 clk_src = ~clk_src;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  logic [5:0] win_match [4] = '{6'h20, 6'h21, 6'h22, 6'h23};
  logic [5:0] win_mask [2][4] = '{'{6'h3F, 6'h3F, 6'h3F, 6'h3F}, '{6'h3F, 6'h20, 6'h3F, 6'h3F}};
  int         win_wait [4] = '{1, 0, 0, 0};

  function automatic int sel_window(input logic [5:0] a, input int k);
    for (int i = 0; i < 4; i++)
      if ((a & win_mask[k][i]) == (win_match[i] & win_mask[k][i])) return i;
    return -1;
  endfunction

  function automatic logic [3:0] exp_cs(input logic [5:0] a, input int k);
    logic [3:0] r;
    int s;
    r = 4'hF;
    s = sel_window(a, k);
    if (s >= 0) r[s] = 1'b0;
    return r;
  endfunction

  function automatic int exp_wait(input logic [5:0] a, input int k);
    int s;
    s = sel_window(a, k);
    return (WAIT_EN && s >= 0) ? win_wait[s] : 0;
  endfunction

  // Model: position within the current CPU cycle; LOW for HALF edges, then HIGH for HALF*(1+wait).
  int   m_pos [2] = '{0, 0};
  int   m_hi [2] = '{HALF, HALF};
  int   tick = 0;
  int   last_rise [2] = '{-1, -1};
  int   period [2] = '{0, 0};
  logic prev_clk [2] = '{1'b0, 1'b0};

  task automatic step();
    logic       oc [2];
    logic       ow [2];
    logic       owe [2];
    logic [3:0] ocs [2];
    @(posedge clk_src);
    tick++;
    for (int k = 0; k < 2; k++) begin
      if (reset) m_pos[k] = 0;
      else begin
        m_pos[k]++;
        if (m_pos[k] == HALF) m_hi[k] = HALF * (1 + exp_wait(address, k));
        else if (m_pos[k] == HALF + m_hi[k]) m_pos[k] = 0;
      end
    end
    @(negedge clk_src);
    oc[0] = cpu_clk_in_a; ow[0] = wait_a; ocs[0] = cs_n_a; owe[0] = ram_we_n_a;
    oc[1] = cpu_clk_in_b; ow[1] = wait_b; ocs[1] = cs_n_b; owe[1] = ram_we_n_b;
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("phi2[%0d]", k), oc[k], m_pos[k] >= HALF);
      check_eq($sformatf("wait_active[%0d]", k), ow[k], m_pos[k] >= 2 * HALF);
      check_eq($sformatf("cs_n[%0d]", k), ocs[k], exp_cs(address, k));
      check_eq($sformatf("ram_we_n[%0d]", k), owe[k], !(cpu_clk_out && !rw));
      if (oc[k] && !prev_clk[k]) begin
        if (last_rise[k] >= 0) period[k] = tick - last_rise[k];
        last_rise[k] = tick;
      end
      prev_clk[k] = oc[k];
    end
  endtask

  task automatic assert_reset();
    reset = 1'b1;
    #1;
    check_eq("rst_phi2_a", cpu_clk_in_a, 1'b0);
    check_eq("rst_wait_a", wait_a, 1'b0);
    check_eq("rst_phi2_b", cpu_clk_in_b, 1'b0);
    check_eq("rst_wait_b", wait_b, 1'b0);
    for (int k = 0; k < 2; k++) begin
      m_pos[k] = 0; last_rise[k] = -1; period[k] = 0; prev_clk[k] = 1'b0;
    end
    repeat (3) step();
  endtask

  task automatic release_reset();
    reset = 1'b0;
    tick = 0;
    for (int n = 0; n < 100 && last_rise[0] < 0; n++) step();
    check_eq("first_rise", last_rise[0], HALF);
  endtask

  initial begin
    int rst_at;
    #1;
    check_eq("reset_phi2", cpu_clk_in_a, 1'b0);
    check_eq("reset_wait", wait_a, 1'b0);
    check_eq("reset_cs_n", cs_n_a, 4'b1110);
    assert_reset();
    release_reset();

    address = 6'h00;
    repeat (200) step();
    check_eq("period_nomatch", period[0], 50);

    address = 6'h20;
    repeat (200) step();
    check_eq("period_cs0_a", period[0], WAIT_EN ? 75 : 50);
    check_eq("period_cs0_b", period[1], WAIT_EN ? 75 : 50);
    check_eq("cs0_prio_b", cs_n_b, 4'b1110);

    address = 6'h23;
    repeat (200) step();
    check_eq("period_cs3", period[0], 50);
    check_eq("cs3_cs_n", cs_n_a, 4'b0111);

    address = 6'h20;
    begin
      int target;
      int n;
      target = WAIT_EN ? 2 * HALF + 10 : HALF + 10;
      for (n = 0; n < 300 && m_pos[0] != target; n++) step();
      check_eq("reach_stretch", m_pos[0], target);
      if (WAIT_EN) check_eq("in_stretch", wait_a, 1'b1);
    end
    assert_reset();
    release_reset();

    for (int i = 0; i < 4; i++) begin
      logic [1:0] v;
      v = 2'(i);
      cpu_clk_out = v[1];
      rw = v[0];
      #1;
      check_eq("we_table", ram_we_n_a, !(v[1] && !v[0]));
    end

    rst_at = $urandom_range(100, 500);
    for (int n = 0; n < 700; n++) begin
      if ($urandom_range(0, 29) == 0) begin
        case ($urandom_range(0, 4))
          0: address = 6'h20;
          1: address = 6'h21;
          2: address = 6'h22;
          3: address = 6'h23;
          default: address = 6'($urandom);
        endcase
      end
      cpu_clk_out = 1'($urandom);
      rw = 1'($urandom);
      if (n == rst_at) begin
        assert_reset();
        release_reset();
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
